// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction codes, master-state code,
// scheduler states and the speed/period helpers.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_RUN  = 1'b1
  } sched_state_t;

  localparam logic [1:0]  MSM_PLAY   = 2'b01;
  localparam int unsigned PERIOD_MIN = 4;

  // Opposite direction differs only in the MSB of the code.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  // min(score >> 2, 7)
  function automatic logic [2:0] speed_level(input logic [7:0] score);
    return (score[7:5] != 3'd0) ? 3'd7 : score[4:2];
  endfunction

  // Signed 64-bit math so a large STEP never wraps below the floor.
  function automatic longint period_for(input longint base, input longint step,
                                        input logic [2:0] lvl);
    longint p;
    p = base - step * longint'(lvl);
    return (p < longint'(PERIOD_MIN)) ? longint'(PERIOD_MIN) : p;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce filter for one raw push button;
// emits a one-cycle press pulse on each rising edge of the filtered level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_q2;
        cnt   <= '0;
        press <= sync_q2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Snake move scheduler: debounced direction buttons feed a 2-entry queue,
// a score-dependent down-counter issues MOVE_EN and pops the next direction.
module move_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned BASE_PERIOD     = 10_000_000,
  parameter int unsigned STEP_PERIOD     = 1_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] MSM_state,
  input  logic       BTNU,
  input  logic       BTNR,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic [7:0] SCORE,
  output logic       MOVE_EN,
  output logic [1:0] DIR,
  output logic [2:0] SPEED_LEVEL,
  output logic [1:0] QUEUE_CNT
);

  localparam int unsigned PERIOD_CAP = (BASE_PERIOD > PERIOD_MIN) ? BASE_PERIOD : PERIOD_MIN;
  localparam int unsigned CNT_W      = $clog2(PERIOD_CAP);

  sched_state_t     state;
  logic [CNT_W-1:0] tick_cnt;
  dir_t             dir_q;
  dir_t             fifo_0;
  dir_t             fifo_1;
  logic [1:0]       q_cnt;

  logic [3:0]       press;
  logic [2:0]       lvl_now;
  logic [CNT_W-1:0] reload_val;
  logic             evt_valid;
  dir_t             evt_dir;
  dir_t             ref_dir;
  logic             in_play;
  logic             tick;
  logic             push;
  logic             pop;

  // press bit index equals the direction code it requests
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up    (.clk(CLK), .rst(RESET), .btn(BTNU), .press(press[0]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (.clk(CLK), .rst(RESET), .btn(BTNR), .press(press[1]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down  (.clk(CLK), .rst(RESET), .btn(BTND), .press(press[2]));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left  (.clk(CLK), .rst(RESET), .btn(BTNL), .press(press[3]));

  always_comb begin
    lvl_now    = speed_level(SCORE);
    reload_val = CNT_W'(period_for(longint'(BASE_PERIOD), longint'(STEP_PERIOD), lvl_now) - 64'sd1);

    evt_valid = |press;
    if (press[0])      evt_dir = DIR_UP;
    else if (press[1]) evt_dir = DIR_RIGHT;
    else if (press[2]) evt_dir = DIR_DOWN;
    else               evt_dir = DIR_LEFT;

    // Reference is the pre-pop tail, so a simultaneous pop never changes the verdict.
    if (q_cnt == 2'd2)      ref_dir = fifo_1;
    else if (q_cnt == 2'd1) ref_dir = fifo_0;
    else                    ref_dir = dir_q;

    in_play = (state == SCHED_RUN) && (MSM_state == MSM_PLAY);
    tick    = in_play && (tick_cnt == '0);
    pop     = tick && (q_cnt != 2'd0);
    push    = in_play && evt_valid && (q_cnt != 2'd2) &&
              (evt_dir != ref_dir) && (evt_dir != reverse_dir(ref_dir));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= SCHED_IDLE;
      tick_cnt    <= '0;
      MOVE_EN     <= 1'b0;
      dir_q       <= DIR_RIGHT;
      SPEED_LEVEL <= 3'd0;
      q_cnt       <= 2'd0;
      fifo_0      <= DIR_UP;
      fifo_1      <= DIR_UP;
    end else begin
      MOVE_EN <= 1'b0;
      if (state == SCHED_IDLE) begin
        tick_cnt <= '0;
        q_cnt    <= 2'd0;
        dir_q    <= DIR_RIGHT;
        if (MSM_state == MSM_PLAY) begin
          state       <= SCHED_RUN;
          tick_cnt    <= reload_val;
          SPEED_LEVEL <= lvl_now;
        end
      end else if (MSM_state != MSM_PLAY) begin
        state    <= SCHED_IDLE;
        tick_cnt <= '0;
        q_cnt    <= 2'd0;
        dir_q    <= DIR_RIGHT;
      end else begin
        if (tick) begin
          tick_cnt    <= reload_val;
          SPEED_LEVEL <= lvl_now;
          MOVE_EN     <= 1'b1;
          if (pop) dir_q <= fifo_0;
        end else begin
          tick_cnt <= tick_cnt - 1'b1;
        end

        case ({push, pop})
          2'b10: begin
            if (q_cnt == 2'd0) fifo_0 <= evt_dir;
            else               fifo_1 <= evt_dir;
            q_cnt <= q_cnt + 2'd1;
          end
          2'b01: begin
            fifo_0 <= fifo_1;
            q_cnt  <= q_cnt - 2'd1;
          end
          // push needs room and pop needs an entry, so here exactly one entry is held
          2'b11: fifo_0 <= evt_dir;
          default: ;
        endcase
      end
    end
  end

  assign DIR       = dir_q;
  assign QUEUE_CNT = q_cnt;

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: constant-table and hand sequences for the corner
// cases, plus randomized traffic checked against a queue-based reference model.
module tb_move_scheduler;

  localparam int BASE = 20;
  localparam int STEP = 2;
  localparam int DB   = 3;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] msm   = 2'b00;
  logic [3:0] btn   = 4'b0000;  // bit index = direction code (U,R,D,L)
  logic [7:0] score = 8'd0;
  logic       move_en;
  logic [1:0] dir;
  logic [2:0] speed;
  logic [1:0] qcnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  move_scheduler #(.BASE_PERIOD(BASE), .STEP_PERIOD(STEP), .DEBOUNCE_CYCLES(DB)) dut (
    .CLK(clk), .RESET(rst), .MSM_state(msm),
    .BTNU(btn[0]), .BTNR(btn[1]), .BTND(btn[2]), .BTNL(btn[3]),
    .SCORE(score), .MOVE_EN(move_en), .DIR(dir), .SPEED_LEVEL(speed), .QUEUE_CNT(qcnt)
  );

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  int         cyc = 0;
  bit         m_run;
  logic [1:0] m_dir;
  int         m_lvl;
  bit         m_move;
  int         m_next;
  logic [1:0] m_q[$];
  logic [3:0] m_flt;
  int         m_diff[4];
  logic [3:0] m_evt[int];
  logic [3:0] m_ev;
  int         m_ed;
  int         m_ref;
  bit         m_acc;

  function automatic int lvl_of(int s);
    return (s / 4 > 7) ? 7 : s / 4;
  endfunction

  function automatic int period_of(int l);
    int p;
    p = BASE - STEP * l;
    return (p < 4) ? 4 : p;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_run = 0; m_dir = 2'b01; m_lvl = 0; m_move = 0;
      m_q.delete(); m_evt.delete(); m_flt = 4'b0;
      foreach (m_diff[i]) m_diff[i] = 0;
    end else begin
      m_ev = 4'b0;
      if (m_evt.exists(cyc)) begin
        m_ev = m_evt[cyc];
        m_evt.delete(cyc);
      end
      // a raw level is believed after DB consecutive samples; a press reaches
      // the queue 3 edges after its last confirming sample (sync + edge detect)
      for (int b = 0; b < 4; b++) begin
        if (btn[b] != m_flt[b]) begin
          m_diff[b]++;
          if (m_diff[b] == DB) begin
            m_flt[b] = btn[b];
            m_diff[b] = 0;
            if (btn[b])
              m_evt[cyc+3] = (m_evt.exists(cyc+3) ? m_evt[cyc+3] : 4'b0) | (4'b1 << b);
          end
        end else begin
          m_diff[b] = 0;
        end
      end
      m_move = 0;
      if (!m_run) begin
        m_dir = 2'b01;
        m_q.delete();
        if (msm == 2'b01) begin
          m_run  = 1;
          m_lvl  = lvl_of(score);
          m_next = cyc + period_of(m_lvl);
        end
      end else if (msm != 2'b01) begin
        m_run = 0;
        m_dir = 2'b01;
        m_q.delete();
      end else begin
        m_acc = 0;
        if (m_ev != 4'b0) begin
          m_ed = 0;
          for (int b = 3; b >= 0; b--) if (m_ev[b]) m_ed = b;
          m_ref = (m_q.size() > 0) ? int'(m_q[$]) : int'(m_dir);
          m_acc = (m_ed != m_ref) && (m_ed != (m_ref ^ 2)) && (m_q.size() < 2);
        end
        if (cyc == m_next) begin
          m_move = 1;
          if (m_q.size() > 0) m_dir = m_q.pop_front();
          m_lvl  = lvl_of(score);
          m_next = cyc + period_of(m_lvl);
        end
        if (m_acc) m_q.push_back(2'(m_ed));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_move_en", int'(move_en), int'(m_move));
      check("model_dir", int'(dir), int'(m_dir));
      check("model_speed", int'(speed), m_lvl);
      check("model_qcnt", int'(qcnt), m_q.size());
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_move(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!move_en && n < 200);
    if (!move_en) $display("FAIL wait_move: got no MOVE_EN expected a pulse within 200 cycles");
  endtask

  task automatic enter_run(input int s);
    msm   = 2'b00;
    score = 8'(s);
    repeat (2) @(negedge clk);
    msm = 2'b01;
  endtask

  typedef struct {
    int score;
    int lvl;
    int period;
  } vec_t;

  vec_t tbl[8];
  int   n;

  initial begin
    tbl[0] = '{0,   0, 20};
    tbl[1] = '{3,   0, 20};
    tbl[2] = '{4,   1, 18};
    tbl[3] = '{12,  3, 14};
    tbl[4] = '{27,  6,  8};
    tbl[5] = '{28,  7,  6};
    tbl[6] = '{200, 7,  6};
    tbl[7] = '{255, 7,  6};

    repeat (3) @(negedge clk);
    check("rst_move_en", int'(move_en), 0);
    check("rst_dir", int'(dir), 1);
    check("rst_speed", int'(speed), 0);
    check("rst_qcnt", int'(qcnt), 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // first move lands exactly PERIOD cycles after RUN entry
    for (int i = 0; i < 8; i++) begin
      enter_run(tbl[i].score);
      wait_move(n);
      check("tbl_period", n - 1, tbl[i].period);
      check("tbl_level", int'(speed), tbl[i].lvl);
    end

    // score change mid-interval only affects the following interval
    enter_run(0);
    repeat (10) @(negedge clk);
    score = 8'd12;
    wait_move(n);
    check("mid_first_interval", n + 10, BASE + 1);
    wait_move(n);
    check("lvl3_interval", n, 14);
    check("lvl3_speed", int'(speed), 3);
    score = 8'd200;
    wait_move(n);
    check("lvl3_interval_again", n, 14);
    check("lvl7_speed", int'(speed), 7);
    wait_move(n);
    check("lvl7_interval", n, 6);

    // reverse press dropped, then U,L queued and consumed in order
    enter_run(0);
    btn = 4'b1000;
    repeat (5) @(negedge clk);
    btn = 4'b0000;
    repeat (7) @(negedge clk);
    check("reverse_drop_qcnt", int'(qcnt), 0);
    wait_move(n);
    check("reverse_drop_dir", int'(dir), 1);
    btn = 4'b0001; repeat (2) @(negedge clk);
    btn = 4'b1001; repeat (3) @(negedge clk);
    btn = 4'b1000; repeat (2) @(negedge clk);
    btn = 4'b0000; repeat (3) @(negedge clk);
    check("two_queued_qcnt", int'(qcnt), 2);
    wait_move(n);
    check("pop1_dir", int'(dir), 0);
    check("pop1_qcnt", int'(qcnt), 1);
    wait_move(n);
    check("pop2_dir", int'(dir), 3);
    check("pop2_qcnt", int'(qcnt), 0);

    // 2-cycle glitch ignored; simultaneous U+R keeps only U
    btn = 4'b0001; repeat (2) @(negedge clk);
    btn = 4'b0000; repeat (8) @(negedge clk);
    check("glitch_qcnt", int'(qcnt), 0);
    btn = 4'b0011; repeat (5) @(negedge clk);
    btn = 4'b0000; repeat (2) @(negedge clk);
    check("simul_qcnt", int'(qcnt), 1);
    wait_move(n);
    check("simul_dir", int'(dir), 0);

    // full queue drops a third valid press; leaving PLAY flushes next cycle
    btn = 4'b0010; repeat (2) @(negedge clk);
    btn = 4'b0011; repeat (2) @(negedge clk);
    btn = 4'b1011; repeat (1) @(negedge clk);
    btn = 4'b1001; repeat (2) @(negedge clk);
    btn = 4'b1000; repeat (2) @(negedge clk);
    btn = 4'b0000; repeat (3) @(negedge clk);
    check("full_drop_qcnt", int'(qcnt), 2);
    msm = 2'b00;
    @(negedge clk);
    check("leave_qcnt", int'(qcnt), 0);
    check("leave_dir", int'(dir), 1);
    check("leave_move_en", int'(move_en), 0);

    // asynchronous reset mid-interval with a full queue
    enter_run(12);
    btn = 4'b0001; repeat (2) @(negedge clk);
    btn = 4'b1001; repeat (3) @(negedge clk);
    btn = 4'b1000; repeat (2) @(negedge clk);
    btn = 4'b0000; repeat (2) @(negedge clk);
    check("pre_rst_qcnt", int'(qcnt), 2);
    check("pre_rst_speed", int'(speed), 3);
    rst = 1'b1;
    #1;
    check("async_rst_move_en", int'(move_en), 0);
    check("async_rst_dir", int'(dir), 1);
    check("async_rst_speed", int'(speed), 0);
    check("async_rst_qcnt", int'(qcnt), 0);
    score = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_move(n);
    check("post_rst_first_move", n - 1, BASE);
    check("post_rst_dir", int'(dir), 1);
    check("post_rst_qcnt", int'(qcnt), 0);

    // randomized traffic, checked continuously against the model
    msm = 2'b01;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 7))
          0, 1, 2: btn = 4'b0000;
          3:       btn = 4'b0001;
          4:       btn = 4'b0010;
          5:       btn = 4'b0100;
          6:       btn = 4'b1000;
          default: btn = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 59) == 0) score = 8'($urandom_range(0, 255));
      if (msm == 2'b01) begin
        if ($urandom_range(0, 299) == 0) msm = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 9) == 0) begin
        msm = 2'b01;
      end
    end

    btn = 4'b0000;
    msm = 2'b00;
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter BASE_PERIOD, default 10_000_000, clock cycles between moves at speed level 0.
REQ-002 Parameter STEP_PERIOD, default 1_000_000, period reduction per speed level.
REQ-003 Parameter DEBOUNCE_CYCLES, default 1_000_000, stable cycles before a button is accepted.
REQ-004 CLK  in  1  system clock; all state on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 MSM_state  in  2  master game state; 2'b01 = PLAY, any other value = not playing.
REQ-007 BTNU, BTNR, BTND, BTNL  in  1 each  raw asynchronous push buttons.
REQ-008 SCORE  in  8  current score, unsigned.
REQ-009 MOVE_EN  out  1  single-cycle pulse commanding the snake datapath to advance one cell.
REQ-010 DIR  out  2  direction for the move: 00 up, 01 right, 10 down, 11 left.
REQ-011 SPEED_LEVEL  out  3  speed level currently in effect.
REQ-012 QUEUE_CNT  out  2  occupancy of the direction queue (0..2).

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer updating its filtered level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-014 A press event SHALL be the rising edge of the filtered level; simultaneous events SHALL be resolved U > R > D > L, lower-priority ones discarded.
REQ-015 A press event SHALL be dropped if its direction equals, or is the reverse (XOR 2'b10) of, the reference direction: the queue tail if QUEUE_CNT>0, else DIR.
REQ-016 Accepted events SHALL enter a 2-entry FIFO; events arriving when full SHALL be dropped.
REQ-017 States: IDLE, RUN. IDLE->RUN when MSM_state==2'b01; RUN->IDLE the cycle after MSM_state leaves 2'b01.
REQ-018 In IDLE: tick counter held at 0, FIFO flushed, DIR=01, MOVE_EN=0; press events ignored.
REQ-019 In RUN a down-counter SHALL load PERIOD-1 and decrement each cycle; on reaching 0 it reloads and MOVE_EN pulses high for exactly one cycle.
REQ-020 On the edge asserting MOVE_EN, DIR SHALL take the FIFO head (which is popped) if QUEUE_CNT>0, else hold.
REQ-021 Push and pop in the same cycle SHALL both occur; QUEUE_CNT unchanged, reverse check uses pre-pop tail.
REQ-022 Level = min(SCORE>>2, 7); PERIOD = max(BASE_PERIOD - STEP_PERIOD*level, 4), computed with width sufficient to avoid underflow.
REQ-023 SPEED_LEVEL and PERIOD SHALL be sampled only at counter reload; a SCORE change mid-interval takes effect from the next interval.
REQ-024 First MOVE_EN after IDLE->RUN SHALL occur exactly PERIOD cycles after entering RUN.

Reset
REQ-025 RESET SHALL asynchronously force: state IDLE, MOVE_EN=0, DIR=01, SPEED_LEVEL=0, QUEUE_CNT=0, counters and debouncers cleared, filtered levels 0.
REQ-026 Reset asserted mid-interval or with a full queue SHALL discard all pending moves; no MOVE_EN pulse in the cycle following deassertion.

Structure
REQ-027 Direction codes, PLAY state code and reverse function SHALL live in shared package snake_pkg, reused by the snake datapath and next-state logic.
REQ-028 Debouncer SHALL be one sub-module, btn_debounce, instantiated four times; FIFO and scheduler remain in move_scheduler.

Verification (BASE_PERIOD=20, STEP_PERIOD=2, DEBOUNCE_CYCLES=3)
REQ-029 Reset, MSM_state=01, SCORE=0 -> MOVE_EN pulses every 20 cycles, first at cycle 20, DIR=01, SPEED_LEVEL=0.
REQ-030 SCORE=12 mid-interval -> current interval stays 20 cycles; next intervals 14 cycles, SPEED_LEVEL=3; SCORE=200 -> level 7, period 6.
REQ-031 DIR=01, press L -> dropped, QUEUE_CNT=0; press U then L within one interval -> QUEUE_CNT=2, next two moves DIR=00 then 11.
REQ-032 Button glitch of 2 cycles -> no event; U and R pressed same cycle -> only U queued.
REQ-033 Queue full plus third valid press -> dropped, QUEUE_CNT=2; MSM_state->00 -> next cycle QUEUE_CNT=0, DIR=01, no MOVE_EN.
REQ-034 RESET asserted with counter at 5 and QUEUE_CNT=2 -> all outputs at reset values immediately, first post-reset MOVE_EN exactly 20 cycles after RUN entry.
